// File: rtl/me_search_ctrl.sv
// ---------------------------------------------------------------------------
// acc_pkg / me_search_ctrl
//
// acc_pkg holds the memory request/response and SAD result types shared by
// the accelerator blocks.
//
// me_search_ctrl is a full-search motion-estimation controller. It walks every
// candidate position (cx, cy) of the reference block inside the search window
// and streams PortNum pixels per cycle from both image memories. It builds a
// per-candidate sum of absolute differences and keeps the smallest SAD along
// with that candidate's top-left search-memory address.
//
// Ports
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   start a full search; only sampled in IDLE
//   busy_o       out  high while beats are issued or the last one drains
//   done_o       out  one-cycle pulse; best_o is final from here on
//   smem_req_o   out  search memory request (read addresses; writes tied off)
//   smem_res_i   in   search memory data, one cycle after the address
//   rmem_raddr_o out  reference memory read addresses
//   rmem_rdata_i in   reference memory data, one cycle after the address
//   best_o       out  minimum SAD and its candidate address
// ---------------------------------------------------------------------------
package acc_pkg;
    localparam int SMemReadPortNum = 4;
    localparam int SMemAddrW       = 10;
    localparam int PixW            = 8;
    localparam int SadW            = 17;

    typedef struct packed {
        logic                                       write;
        logic [SMemAddrW-1:0]                       waddr;
        logic [PixW-1:0]                            wdata;
        logic [SMemReadPortNum-1:0][SMemAddrW-1:0]  raddr;
    } smem_req_t;

    typedef struct packed {
        logic [SMemReadPortNum-1:0][PixW-1:0] data;
    } smem_res_t;

    typedef struct packed {
        logic [SadW-1:0]      sad;
        logic [SMemAddrW-1:0] addr;
    } sad_t;
endpackage

module me_search_ctrl #(
    parameter int SImgSize = 31,
    parameter int RImgSize = 16,
    parameter int PortNum  = acc_pkg::SMemReadPortNum
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output acc_pkg::smem_req_t            smem_req_o,
    input  acc_pkg::smem_res_t            smem_res_i,
    output logic [PortNum-1:0][7:0]       rmem_raddr_o,
    input  logic [PortNum-1:0][7:0]       rmem_rdata_i,
    output acc_pkg::sad_t                 best_o
);
    localparam int AW     = acc_pkg::SMemAddrW;
    localparam int SW     = acc_pkg::SadW;
    localparam int NCand  = SImgSize - RImgSize + 1;
    localparam int NBx    = RImgSize / PortNum;
    localparam int CW     = ($clog2(NCand) > 0) ? $clog2(NCand) : 1;
    localparam int RW     = ($clog2(RImgSize) > 0) ? $clog2(RImgSize) : 1;
    localparam int BW     = ($clog2(NBx) > 0) ? $clog2(NBx) : 1;
    localparam int BSW    = 8 + $clog2(PortNum);

    localparam logic [SW-1:0] SadInit = {SW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Scan counters: candidate position (cx, cy) and beat position inside the
    // block (bx = column group of PortNum pixels, ry = block row).
    logic [CW-1:0] r_cx;
    logic [CW-1:0] r_cy;
    logic [RW-1:0] r_ry;
    logic [BW-1:0] r_bx;

    logic          w_bx_last;
    logic          w_ry_last;
    logic          w_cx_last;
    logic          w_cy_last;
    logic          w_cand_last;
    logic          w_all_last;
    logic          w_run;

    logic [RW-1:0] w_rx;
    logic [AW-1:0] w_sbase;
    logic [7:0]    w_rbase;
    logic [AW-1:0] w_caddr;

    logic                r_vld_p1;
    logic                r_last_p1;
    logic [AW-1:0]       r_caddr_p1;

    logic [BSW-1:0]      w_beat_sum;
    logic [SW-1:0]       w_cand_sad;
    logic [SW-1:0]       r_acc;
    acc_pkg::sad_t       r_best;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (w_all_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_run       = (r_state == S_RUN);
    assign w_bx_last   = (r_bx == BW'(NBx - 1));
    assign w_ry_last   = (r_ry == RW'(RImgSize - 1));
    assign w_cx_last   = (r_cx == CW'(NCand - 1));
    assign w_cy_last   = (r_cy == CW'(NCand - 1));
    assign w_cand_last = w_bx_last & w_ry_last;
    assign w_all_last  = w_cand_last & w_cx_last & w_cy_last;

    // Nested raster counters; each level only moves when all inner levels wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bx <= '0;
            r_ry <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == S_IDLE) begin
            r_bx <= '0;
            r_ry <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_run) begin
            r_bx <= w_bx_last ? '0 : r_bx + 1'b1;
            if (w_bx_last) begin
                r_ry <= w_ry_last ? '0 : r_ry + 1'b1;
            end
            if (w_cand_last) begin
                r_cx <= w_cx_last ? '0 : r_cx + 1'b1;
            end
            if (w_cand_last && w_cx_last) begin
                r_cy <= w_cy_last ? '0 : r_cy + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage p0: beat issue (address generation)
    // -----------------------------------------------------------------------
    assign w_rx    = RW'(r_bx * PortNum);
    assign w_sbase = (AW'(r_cy) + AW'(r_ry)) * AW'(SImgSize) + AW'(r_cx) + AW'(w_rx);
    assign w_rbase = 8'(r_ry) * 8'(RImgSize) + 8'(w_rx);
    assign w_caddr = AW'(r_cy) * AW'(SImgSize) + AW'(r_cx);

    always_comb begin
        smem_req_o       = '0;
        rmem_raddr_o     = '0;
        if (w_run) begin
            for (int p = 0; p < PortNum; p++) begin
                smem_req_o.raddr[p] = w_sbase + AW'(p);
                rmem_raddr_o[p]     = w_rbase + 8'(p);
            end
        end
    end

    // Beat sideband travels with the outstanding read so the data stage knows
    // whether the returning pixels are live and whether they close a candidate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1   <= 1'b0;
            r_last_p1  <= 1'b0;
            r_caddr_p1 <= '0;
        end else begin
            r_vld_p1   <= w_run;
            r_last_p1  <= w_run & w_cand_last;
            r_caddr_p1 <= w_caddr;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1: memory data returns, SAD accumulate and best tracking
    // -----------------------------------------------------------------------
    always_comb begin
        w_beat_sum = '0;
        for (int p = 0; p < PortNum; p++) begin
            w_beat_sum = w_beat_sum + BSW'(abs_diff(smem_res_i.data[p], rmem_rdata_i[p]));
        end
    end

    assign w_cand_sad = r_acc + SW'(w_beat_sum);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc       <= '0;
            r_best.sad  <= SadInit;
            r_best.addr <= '0;
        end else if (r_state == S_IDLE) begin
            r_acc <= '0;
            if (start_i) begin
                r_best.sad  <= SadInit;
                r_best.addr <= '0;
            end
        end else if (r_vld_p1) begin
            if (r_last_p1) begin
                r_acc <= '0;
                // Strict compare so an equal SAD keeps the earlier candidate.
                if (w_cand_sad < r_best.sad) begin
                    r_best.sad  <= w_cand_sad;
                    r_best.addr <= r_caddr_p1;
                end
            end else begin
                r_acc <= w_cand_sad;
            end
        end
    end

    assign best_o = r_best;

endmodule

// File: tb/tb_me_search_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for me_search_ctrl: image memories are modelled with a
// one-cycle read latency and filled with patterns whose best match is known.
// ---------------------------------------------------------------------------
module tb_me_search_ctrl;
    localparam int PN = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     busy;
    logic                     done;
    acc_pkg::smem_req_t       smem_req;
    acc_pkg::smem_res_t       smem_res;
    logic [PN-1:0][7:0]       rmem_raddr;
    logic [PN-1:0][7:0]       rmem_rdata;
    acc_pkg::sad_t            best;

    logic [7:0] simg [0:1023];
    logic [7:0] rimg [0:255];

    int n_chk;
    int n_fail;
    int g_cyc;

    typedef struct {
        int cyc;
        int s0;
        int r0;
    } addr_vec_t;

    typedef struct {
        int mode;
        int exp_sad;
        int exp_addr;
        int pulse_a;
        int pulse_b;
        bit chk_addr;
    } run_vec_t;

    addr_vec_t av [5];
    run_vec_t  rv [3];

    me_search_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .smem_req_o   (smem_req),
        .smem_res_i   (smem_res),
        .rmem_raddr_o (rmem_raddr),
        .rmem_rdata_i (rmem_rdata),
        .best_o       (best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: address sampled at the edge, data visible the next cycle.
    always @(posedge clk) begin
        for (int p = 0; p < PN; p++) begin
            smem_res.data[p] <= simg[smem_req.raddr[p]];
            rmem_rdata[p]    <= rimg[rmem_raddr[p]];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        g_cyc++;
    endtask

    // mode 0: exact match at (cx=3, cy=9); 1: uniform 10; 2: search 255 / ref 0
    task automatic fill_images(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       simg[a] = 8'((7 * a) % 256);
                1:       simg[a] = 8'd10;
                default: simg[a] = 8'd255;
            endcase
        end
        for (int ry = 0; ry < 16; ry++) begin
            for (int rx = 0; rx < 16; rx++) begin
                case (mode)
                    0:       rimg[ry*16+rx] = simg[(9+ry)*31 + 3 + rx];
                    1:       rimg[ry*16+rx] = 8'd10;
                    default: rimg[ry*16+rx] = 8'd0;
                endcase
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_best_sad"}, best.sad, 17'h1FFFF);
        chk({tag, "_best_addr"}, best.addr, 0);
        chk({tag, "_saddr"}, smem_req.raddr, 0);
        chk({tag, "_raddr"}, rmem_raddr, 0);
        chk({tag, "_wr_tie"}, {smem_req.write, smem_req.waddr, smem_req.wdata}, 0);
    endtask

    // Starts a search in the current cycle (cycle 0), monitors it until done,
    // and returns positioned in the cycle after done.
    task automatic do_search(input run_vec_t r, input string tag,
                             output int t0, output int done_abs);
        int done_at;
        int busy_n;
        int busy_first;
        int busy_last;
        fill_images(r.mode);
        t0         = g_cyc;
        done_at    = -1;
        busy_n     = 0;
        busy_first = -1;
        busy_last  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 17000; c++) begin
            if (busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (r.chk_addr) begin
                foreach (av[i]) begin
                    if (av[i].cyc == c) begin
                        for (int p = 0; p < PN; p++) begin
                            chk($sformatf("%s_saddr_c%0d_p%0d", tag, c, p),
                                smem_req.raddr[p], av[i].s0 + p);
                            chk($sformatf("%s_raddr_c%0d_p%0d", tag, c, p),
                                rmem_raddr[p], av[i].r0 + p);
                        end
                    end
                end
            end
            if (done && done_at < 0) done_at = c;
            start = (c == r.pulse_a) || (c == r.pulse_b);
            if (done_at >= 0) begin
                tick();
                start = 1'b0;
                break;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_at, 16386);
        chk({tag, "_busy_count"}, busy_n, 16385);
        chk({tag, "_busy_first"}, busy_first, 1);
        chk({tag, "_busy_last"}, busy_last, 16385);
        chk({tag, "_best_sad"}, best.sad, r.exp_sad);
        chk({tag, "_best_addr"}, best.addr, r.exp_addr);
        // Cycle after done: idle, result held.
        chk({tag, "_post_busy"}, busy, 0);
        chk({tag, "_post_done"}, done, 0);
        done_abs = t0 + done_at;
    endtask

    initial begin
        int t0;
        int d_abs;
        int run0_t0;
        int run1_done;

        av[0] = '{cyc: 1,     s0: 0,   r0: 0};
        av[1] = '{cyc: 5,     s0: 31,  r0: 16};
        av[2] = '{cyc: 65,    s0: 1,   r0: 0};
        av[3] = '{cyc: 1025,  s0: 31,  r0: 0};
        av[4] = '{cyc: 16384, s0: 957, r0: 252};

        rv[0] = '{mode: 0, exp_sad: 0,     exp_addr: 282, pulse_a: 100, pulse_b: 16386, chk_addr: 1'b1};
        rv[1] = '{mode: 1, exp_sad: 0,     exp_addr: 0,   pulse_a: -1,  pulse_b: -1,    chk_addr: 1'b0};
        rv[2] = '{mode: 2, exp_sad: 65280, exp_addr: 0,   pulse_a: -1,  pulse_b: -1,    chk_addr: 1'b0};

        n_chk     = 0;
        n_fail    = 0;
        g_cyc     = 0;
        run0_t0   = 0;
        run1_done = 0;
        start     = 1'b0;
        rst_n     = 1'b0;
        fill_images(0);

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        check_reset_outputs("idle");

        // Back-to-back runs: run1 starts in the cycle right after run0's done.
        for (int i = 0; i < 3; i++) begin
            do_search(rv[i], $sformatf("run%0d", i), t0, d_abs);
            if (i == 0) run0_t0 = t0;
            if (i == 1) run1_done = d_abs;
        end
        chk("restart_done_cycle", run1_done - run0_t0, 32773);

        // Reset in the middle of a search.
        repeat (2) tick();
        fill_images(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5000; c++) tick();
        chk("midrun_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("midrun_rst_nodone_%0d", c), done, 0);
        end
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        do_search('{mode: 0, exp_sad: 0, exp_addr: 282, pulse_a: -1, pulse_b: -1, chk_addr: 1'b1},
                  "rerun", t0, d_abs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/me_search_ctrl.md
# me_search_ctrl

Full-search motion-estimation controller. It scans every candidate position of the reference block inside the search window and drives the read ports of the search-image memory and the reference-image memory. It accumulates the 4-pixel-per-cycle absolute differences into a per-candidate SAD and reports the minimum SAD with its search-memory address. It sits between the top-level start/done control and the two image memories, using the `acc_pkg` request, response and SAD types.

## Interface
- `SImgSize`, 31: search image side length in pixels.
- `RImgSize`, 16: reference block side length in pixels.
- `PortNum`, 4: pixels read per cycle; equals `acc_pkg::SMemReadPortNum`; must divide `RImgSize`.

One clock; reset is asynchronous and active-low.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `start_i` in 1: start a full search; sampled only in IDLE.
- `busy_o` out 1: high in RUN and DRAIN.
- `done_o` out 1: one-cycle pulse; `best_o` valid from this cycle until next start.
- `smem_req_o` out `acc_pkg::smem_req_t`: search memory request. `write`, `waddr` and `wdata` are tied to 0.
- `smem_res_i` in `acc_pkg::smem_res_t`: search memory data, valid 1 cycle after address.
- `rmem_raddr_o` out `[PortNum-1:0][7:0]`: reference memory read addresses.
- `rmem_rdata_i` in `[PortNum-1:0][7:0]`: reference memory data, valid 1 cycle after address.
- `best_o` out `acc_pkg::sad_t`: minimum SAD and its candidate top-left address.

## Operation
- **Candidates.** `cx`, `cy` each range 0..`SImgSize`-`RImgSize` (0..15), giving 256 candidates.
  - Raster order: `cx` is the inner loop, `cy` the outer loop.
- **Beats.** Each candidate takes `RImgSize*RImgSize/PortNum` = 64 beats, in raster order over the block.
  - `rx` steps by `PortNum` (inner), `ry` steps by 1 (outer).
- **Addresses for beat k.** For port p:
  - search: `smem_req_o.raddr[p] = (cy+ry)*SImgSize + cx + rx + p`. Maximum is 960, which fits 10 bits.
  - reference: `rmem_raddr_o[p] = ry*RImgSize + rx + p`.
- **Beat sum.** Sum over p of `|smem_res_i.data[p] - rmem_rdata_i[p]|`, computed unsigned with no wrap; width 10 bits.
  - The beat sum is added to a 17-bit accumulator.
  - The maximum per-candidate SAD is 65280, so the accumulator cannot overflow.
- **Candidate close (last beat).** `cand_sad = acc + beat_sum`.
  - If `cand_sad < best.sad` (strict), `best` becomes {`cand_sad`, `cy*SImgSize+cx`}.
  - `acc` clears to 0 in the same cycle.
  - Ties keep the earlier candidate.
- **States.**
  - IDLE: on `start_i` → RUN. Also initialises `best` to {17'h1FFFF, 0} and clears `acc` and all counters.
  - RUN: issues one beat per cycle with no bubbles, across candidate boundaries too. After the 16384th beat → DRAIN.
  - DRAIN: one cycle; consumes the final beat's data and closes the last candidate → DONE.
  - DONE: `done_o`=1 for one cycle → IDLE.
- **Ignored inputs.** `start_i` outside IDLE is ignored. `smem_res_i` and `rmem_rdata_i` are ignored unless a beat was issued in the previous cycle.
- **Idle outputs.** Outside RUN, all read addresses are 0.

## Timing
- Memory read latency is exactly 1 cycle.
  - Beat issued in cycle t has its data consumed in cycle t+1.
  - `acc` and `best` update at the end of t+1.
- Start at cycle 0 (`start_i` high in IDLE):
  - first beat issued in cycle 1;
  - last beat issued in cycle 16384;
  - DRAIN in cycle 16385;
  - `done_o` high in cycle 16386.
  - Total 16386 cycles start-to-done.
- `busy_o` is high in cycles 1..16385.
- A new start is accepted at the earliest in cycle 16387.
- **Reset values:**
  - `busy_o`=0, `done_o`=0, state IDLE;
  - `best_o`={17'h1FFFF, 10'd0};
  - all addresses 0, `acc`=0, counters 0.
- **Reset mid-run:**
  - immediate return to IDLE with the reset values above;
  - no `done_o`, partial `best` discarded;
  - the next `start_i` after reset release runs a complete search.
- `best_o` holds its value after DONE until the next accepted start reinitialises it.

## Test plan
- **Address sequence.** Issue `start_i`.
  - Cycle 1 search addresses are 0,1,2,3 and reference addresses 0,1,2,3.
  - Cycle 5 search addresses are 31..34 and reference addresses 16..19.
  - Cycle 65 (candidate cx=1) search addresses are 1..4.
  - Cycle 1025 (cy=1, cx=0) search addresses are 31..34.
- **Exact match.** Search image pixel = (7*addr)%256; reference = the block copied from cx=3, cy=9.
  - `done_o` in cycle 16386 with `best_o`={0, 282}.
  - `busy_o` high in exactly cycles 1..16385.
- **Uniform tie.** All pixels 10 in both images → `best_o`={0, 0} (first candidate kept).
- **Maximum SAD.** Search all 255, reference all 0 → `best_o`={65280, 0}; no overflow.
- **Ignored start.** Pulse `start_i` in cycle 100 and again in cycle 16386.
  - Both are ignored; `done_o` still in cycle 16386 only.
  - A start in cycle 16387 gives `done_o` in cycle 32773.
- **Reset mid-run.** Assert `rst_ni`=0 at cycle 5000.
  - All outputs return to reset values asynchronously; no `done_o`.
  - Restart → the exact-match result is reproduced 16386 cycles later.
